// File: rtl/uart_msg_streamer.sv
// Buffered message sender: up to DEPTH bytes go out over a built-in 8-bit UART TX, optional parity and 2 stop bits.
// Latency: the line falls two edges after a start is sampled, and each byte costs F*CPB+1 cycles.
// Backpressure: none. A start while busy is dropped, and buffer writes are ignored until the message completes.
module uart_msg_streamer #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int BAUD          = 115200,
  parameter int DEPTH         = 32,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int PERIOD_CYCLES = 25_000_000,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_Clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW:0]   i_len,
  input  logic          i_send,
  input  logic          i_periodic_en,
  output logic          o_UART_TX,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_msg_count
);

  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int TW       = $clog2(PERIOD_CYCLES + 1);

  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    byte_q;
  logic          tx_d;
  logic          start_req;
  logic [AW:0]   len_clamped;
  logic          parity_bit;
  logic [7:0]    mem [DEPTH];

  assign start_req   = i_send || (i_periodic_en && (timer_q == TMR_LAST));
  assign len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;
  assign parity_bit  = (PARITY == 2) ? ~^byte_q : ^byte_q;

  assign o_busy = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign o_done = (state_q == S_FINISH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        timer_d = timer_q + TW'(1);
        if (start_req) begin
          timer_d = '0;
          // A zero-length request still counts as a start for the timer but sends nothing.
          if (len_clamped != '0) begin
            state_d = S_LOAD;
            len_d   = len_clamped;
            idx_d   = '0;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          if (idx_q + (AW+1)'(1) < len_q) begin
            idx_d   = idx_q + (AW+1)'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!i_periodic_en) timer_d = '0;

    // Line level is registered from the next state so the pin never glitches on decode.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = byte_q[bit_d];
      S_PARITY: tx_d = parity_bit;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      o_UART_TX   <= 1'b1;
      o_msg_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      o_UART_TX <= tx_d;
      if (state_d == S_FINISH) o_msg_count <= o_msg_count + 8'd1;
    end
  end

  // Buffer RAM is deliberately left unreset.
  always_ff @(posedge i_Clk) begin
    if (i_wr_en && !o_busy) mem[i_wr_addr] <= i_wr_data;
    if (state_q == S_LOAD) byte_q <= mem[idx_q[AW-1:0]];
  end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Bench for uart_msg_streamer: three instances (plain, even parity + 2 stop, odd parity), line decoder
// and done checker pop expectations that the stimulus pushes from a byte-level model.
module tb_uart_msg_streamer;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] len = '0;
  logic [2:0] send = '0;
  logic       pen = 1'b0;
  logic [2:0] tx, busy, done;
  logic [2:0][7:0] cnt;

  always #5 clk = ~clk;

  uart_msg_streamer #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(8), .PARITY(0), .STOP_BITS(1),
                      .PERIOD_CYCLES(500)) u_p0 (
    .i_Clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_len(len), .i_send(send[0]), .i_periodic_en(pen), .o_UART_TX(tx[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_msg_count(cnt[0]));

  uart_msg_streamer #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(8), .PARITY(1), .STOP_BITS(2),
                      .PERIOD_CYCLES(500)) u_p1 (
    .i_Clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_len(len), .i_send(send[1]), .i_periodic_en(1'b0), .o_UART_TX(tx[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_msg_count(cnt[1]));

  uart_msg_streamer #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(8), .PARITY(2), .STOP_BITS(1),
                      .PERIOD_CYCLES(500)) u_p2 (
    .i_Clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_len(len), .i_send(send[2]), .i_periodic_en(1'b0), .o_UART_TX(tx[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_msg_count(cnt[2]));

  // Per-instance frame format: parity present, parity kind, stop length in cycles.
  int np_a[3]  = '{0, 1, 1};
  int ptype[3] = '{0, 1, 2};
  int stopc[3] = '{10, 20, 10};

  typedef struct { int inst; logic [7:0] data; logic par; } frame_t;
  typedef struct { int inst; int dur; logic [7:0] cnt; } msg_t;
  frame_t fr_q[$];
  msg_t   msg_q[$];

  logic [7:0] mem_mdl [8];
  logic [7:0] cnt_mdl [3];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int byte_cycles(input int inst);
    return (10 + np_a[inst] + stopc[inst] / CPB - 1) * CPB + 1;
  endfunction

  task automatic push_exp(input int inst, input int l);
    int n;
    int ones;
    frame_t f;
    msg_t m;
    n = (l > 8) ? 8 : l;
    for (int j = 0; j < n; j++) begin
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(mem_mdl[j][b]);
      f.inst = inst;
      f.data = mem_mdl[j];
      f.par  = (ptype[inst] == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
      fr_q.push_back(f);
    end
    if (n > 0) begin
      cnt_mdl[inst] = cnt_mdl[inst] + 8'd1;
      m.inst = inst;
      m.dur  = n * byte_cycles(inst);
      m.cnt  = cnt_mdl[inst];
      msg_q.push_back(m);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit mdl);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = d;
    tick;
    wr_en = 1'b0;
    if (mdl) mem_mdl[a] = d;
  endtask

  // len is scrambled right after the pulse to show it is latched at start.
  task automatic pulse_send(input int inst, input int l);
    len        = l[3:0];
    send[inst] = 1'b1;
    tick;
    send[inst] = 1'b0;
    len        = 4'($urandom);
  endtask

  task automatic send_msg(input int inst, input int l);
    push_exp(inst, l);
    pulse_send(inst, l);
  endtask

  task automatic wait_done(input int inst, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done[inst]) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    tick;
  endtask

  task automatic count_idle(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy[0]) break;
      n++;
    end
  endtask

  task automatic busy_window(input int cycles, output int b);
    b = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      b += int'(busy[0]);
    end
  endtask

  // Monitor: decodes each line at mid-bit and checks completed messages against the queues.
  bit         m_in [3]   = '{0, 0, 0};
  int         m_cyc [3]  = '{0, 0, 0};
  int         m_busy [3] = '{0, 0, 0};
  logic [7:0] m_data [3];
  logic       m_par [3];
  logic       m_bad [3];
  msg_t       mon_m;
  frame_t     mon_f;
  int         mon_k, mon_sp;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_in[i]   = 1'b0;
        m_busy[i] = 0;
      end else begin
        if (busy[i]) m_busy[i]++;
        if (done[i]) begin
          if (msg_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: inst %0d count %0d with no message pending", i, cnt[i]);
          end else begin
            mon_m = msg_q.pop_front();
            chk("msg_inst", i, mon_m.inst);
            chk("busy_cycles", m_busy[i], mon_m.dur);
            chk("msg_count", int'(cnt[i]), int'(mon_m.cnt));
          end
          m_busy[i] = 0;
        end
        if (!m_in[i]) begin
          if (tx[i] == 1'b0) begin
            m_in[i]  = 1'b1;
            m_cyc[i] = 0;
            m_bad[i] = 1'b0;
          end
        end else begin
          m_cyc[i]++;
        end
        if (m_in[i]) begin
          mon_sp = (9 + np_a[i]) * CPB;
          if (m_cyc[i] < mon_sp && (m_cyc[i] % CPB) == CPB / 2) begin
            mon_k = m_cyc[i] / CPB;
            if (mon_k == 0) begin
              if (tx[i] != 1'b0) m_bad[i] = 1'b1;
            end else if (mon_k <= 8) begin
              m_data[i][mon_k-1] = tx[i];
            end else begin
              m_par[i] = tx[i];
            end
          end
          if (m_cyc[i] >= mon_sp && tx[i] == 1'b0) m_bad[i] = 1'b1;
          if (m_cyc[i] == mon_sp + stopc[i] - 1) begin
            m_in[i] = 1'b0;
            if (fr_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: inst %0d byte %02h with nothing pending", i, m_data[i]);
            end else begin
              mon_f = fr_q.pop_front();
              chk("frame_inst", i, mon_f.inst);
              chk("frame_data", int'(m_data[i]), int'(mon_f.data));
              chk("framing_error", int'(m_bad[i]), 0);
              if (np_a[i] != 0) chk("parity_bit", int'(m_par[i]), int'(mon_f.par));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    int n;
    int b;
    for (int i = 0; i < 3; i++) cnt_mdl[i] = 8'd0;
    repeat (3) tick;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", int'(tx[i]), 1);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_count", int'(cnt[i]), 0);
    end
    rst = 1'b0;
    tick;

    // Basic four-byte message.
    wr(0, 8'h48, 1'b1);
    wr(1, 8'h69, 1'b1);
    wr(2, 8'h0D, 1'b1);
    wr(3, 8'h0A, 1'b1);
    send_msg(0, 4);
    wait_done(0, 1000);

    // Parity and two stop bits on the secondary instances (byte 0 = 0x48).
    send_msg(1, 1);
    wait_done(1, 500);
    send_msg(2, 1);
    wait_done(2, 500);

    // Random messages, lengths beyond DEPTH included.
    for (int r = 0; r < 6; r++) begin
      l = int'($urandom_range(1, 15));
      for (int j = 0; j < ((l > 8) ? 8 : l); j++) wr(j, 8'($urandom), 1'b1);
      send_msg(0, l);
      wait_done(0, 2000);
      repeat ($urandom_range(0, 5)) tick;
    end

    // Periodic auto-send.
    wr(0, 8'h5A, 1'b1);
    len = 4'd1;
    push_exp(0, 1);
    pen = 1'b1;
    count_idle(n);
    chk("period_first", n, 500);
    wait_done(0, 500);
    for (int p = 0; p < 2; p++) begin
      push_exp(0, 1);
      count_idle(n);
      chk("period_gap", n, 500);
      wait_done(0, 500);
    end
    pen = 1'b0;
    tick;

    // Start request and buffer write while busy are both ignored.
    wr(0, 8'h48, 1'b1);
    send_msg(0, 4);
    repeat (150) tick;
    pulse_send(0, 4);
    wr(0, 8'hFF, 1'b0);
    wait_done(0, 1000);
    busy_window(60, b);
    chk("no_requeue_busy", b, 0);
    send_msg(0, 1);
    wait_done(0, 500);

    // Zero length and clamped length.
    pulse_send(0, 0);
    busy_window(40, b);
    chk("len0_busy", b, 0);
    for (int j = 0; j < 8; j++) wr(j, 8'($urandom), 1'b1);
    send_msg(0, 15);
    wait_done(0, 2000);

    // Reset during a data bit (byte 0 is all zeros so the line is low).
    wr(0, 8'h00, 1'b1);
    wr(1, 8'hC3, 1'b1);
    send_msg(0, 4);
    repeat (30) tick;
    rst = 1'b1;
    fr_q.delete();
    msg_q.delete();
    for (int i = 0; i < 3; i++) cnt_mdl[i] = 8'd0;
    tick;
    chk("midrst_tx", int'(tx[0]), 1);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_count", int'(cnt[0]), 0);
    rst = 1'b0;
    tick;
    send_msg(0, 2);
    wait_done(0, 1000);

    repeat (20) tick;
    chk("frames_left", fr_q.size(), 0);
    chk("msgs_left", msg_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
